// File: rtl/packer_pkg.sv
// packer_pkg: shared definitions for the program loader.
//   op_kind_e  - mnemonic descriptors accepted on the input stream (18 kinds)
//   OPC_*      - 4-bit machine opcodes, identical to what the control decoder consumes
//   state_e    - loader FSM states
package packer_pkg;

    typedef enum logic [4:0] {
        OP_LI, OP_LD, OP_ST, OP_MOV,
        OP_ADD, OP_SUB, OP_SHIFT, OP_XOR,
        OP_AND, OP_OR, OP_BANK, OP_JMP,
        OP_BEQ, OP_ANDI, OP_EXCESS, OP_LDR,
        OP_STR, OP_RDX
    } op_kind_e;

    localparam logic [3:0] OPC_LI     = 4'h0;
    localparam logic [3:0] OPC_LD     = 4'h1;
    localparam logic [3:0] OPC_ST     = 4'h2;
    localparam logic [3:0] OPC_MOV    = 4'h3;
    localparam logic [3:0] OPC_ADDSUB = 4'h4;
    localparam logic [3:0] OPC_SHIFT  = 4'h5;
    localparam logic [3:0] OPC_XOR    = 4'h6;
    localparam logic [3:0] OPC_ANDOR  = 4'h7;
    localparam logic [3:0] OPC_BANK   = 4'h8;
    localparam logic [3:0] OPC_JMP    = 4'h9;
    localparam logic [3:0] OPC_BEQ    = 4'hA;
    localparam logic [3:0] OPC_ANDI   = 4'hB;
    localparam logic [3:0] OPC_EXCESS = 4'hC;
    localparam logic [3:0] OPC_LDR    = 4'hD;
    localparam logic [3:0] OPC_STR    = 4'hE;
    localparam logic [3:0] OPC_RDX    = 4'hF;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_e;

endpackage

// File: rtl/instr_packer_if.sv
// instr_packer_if: descriptor stream into the packer.
//   in_valid / in_ready - handshake, beat accepted when both are high
//   in_op               - mnemonic (op_kind_e encoding, 5 bits; out-of-range values are illegal)
//   in_operand          - raw 5-bit operand
// master = descriptor source, slave = packer.
interface instr_packer_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_op;
    logic [4:0] in_operand;

    modport master (output in_valid, in_op, in_operand, input in_ready);
    modport slave  (input in_valid, in_op, in_operand, output in_ready);
endinterface

// File: rtl/op_encoder.sv
// op_encoder: combinational mnemonic -> machine word encoder.
//   in_op, in_operand - descriptor fields
//   word              - {opcode[3:0], operand[4:0]}
//   legal             - 0 for unknown mnemonics or a selector op with in_operand[4] set
module op_encoder
    import packer_pkg::*;
(
    input  logic [4:0] in_op,
    input  logic [4:0] in_operand,
    output logic [8:0] word,
    output logic       legal
);

    logic [3:0] opc;
    logic [4:0] opd;

    always_comb begin
        opc   = OPC_LI;
        opd   = in_operand;
        legal = 1'b1;
        case (in_op)
            OP_LI:     opc = OPC_LI;
            OP_LD:     opc = OPC_LD;
            OP_ST:     opc = OPC_ST;
            OP_MOV:    opc = OPC_MOV;
            // Selector ops share an opcode; the low operand bit picks ADD/AND (1) vs SUB/OR (0),
            // so only 4 bits of raw operand survive.
            OP_ADD: begin opc = OPC_ADDSUB; opd = {in_operand[3:0], 1'b1}; legal = !in_operand[4]; end
            OP_SUB: begin opc = OPC_ADDSUB; opd = {in_operand[3:0], 1'b0}; legal = !in_operand[4]; end
            OP_AND: begin opc = OPC_ANDOR;  opd = {in_operand[3:0], 1'b1}; legal = !in_operand[4]; end
            OP_OR:  begin opc = OPC_ANDOR;  opd = {in_operand[3:0], 1'b0}; legal = !in_operand[4]; end
            OP_SHIFT:  opc = OPC_SHIFT;
            OP_XOR:    opc = OPC_XOR;
            OP_BANK:   opc = OPC_BANK;
            OP_JMP:    opc = OPC_JMP;
            OP_BEQ:    opc = OPC_BEQ;
            OP_ANDI:   opc = OPC_ANDI;
            OP_EXCESS: opc = OPC_EXCESS;
            OP_LDR:    opc = OPC_LDR;
            OP_STR:    opc = OPC_STR;
            OP_RDX:    opc = OPC_RDX;
            default:   legal = 1'b0;
        endcase
        word = {opc, opd};
    end

endmodule

// File: rtl/instr_packer.sv
// instr_packer: program loader. Encodes descriptors from the input stream and writes
// them to consecutive instruction-memory addresses starting at 0.
//   Clk, Reset        - clock, synchronous active-high reset
//   start, finish     - begin (clears counter) / end a load
//   in_if (slave)     - descriptor stream
//   mem_we/addr/wdata - registered instruction-memory write port
//   count             - words written in this load (saturates at 2**AW, never wraps)
//   busy/done/err     - state is LOAD / DONE / ERR
//   checksum          - XOR of written words; present only with PACKER_CHECKSUM_EN defined
module instr_packer
    import packer_pkg::*;
#(
    parameter int IW = 9,
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic          finish,
    instr_packer_if.slave in_if,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [IW-1:0] mem_wdata,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef PACKER_CHECKSUM_EN
    ,
    output logic [IW-1:0] checksum
`endif
);

    state_e        state_q, state_d;
    logic          accept, legal, write, restart;
    logic [8:0]    word;

    op_encoder u_enc (
        .in_op     (in_if.in_op),
        .in_operand(in_if.in_operand),
        .word      (word),
        .legal     (legal)
    );

    // count never exceeds 2**AW, so its MSB alone flags "full".
    assign in_if.in_ready = (state_q == ST_LOAD) && !count[AW] && !Reset;
    assign accept  = in_if.in_valid && in_if.in_ready;
    assign write   = accept && legal;
    assign restart = (state_q != ST_LOAD) && start;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A bad beat wins over a simultaneous finish.
            ST_LOAD: begin
                if (accept && !legal) state_d = ST_ERR;
                else if (finish)      state_d = ST_DONE;
            end
            default: if (start) state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
        end else begin
            mem_we <= write;
            if (write) begin
                mem_addr  <= count[AW-1:0];
                mem_wdata <= IW'(word);
                count     <= count + 1'b1;
            end else if (restart) begin
                count <= '0;
            end
        end
    end

`ifdef PACKER_CHECKSUM_EN
    // Updated on the same edge as mem_wdata so it already includes the word on the bus.
    always_ff @(posedge Clk) begin
        if (Reset)        checksum <= '0;
        else if (write)   checksum <= checksum ^ IW'(word);
        else if (restart) checksum <= '0;
    end
`endif

    assign busy = (state_q == ST_LOAD);
    assign done = (state_q == ST_DONE);
    assign err  = (state_q == ST_ERR);

endmodule

// File: doc/instr_packer.md
# instr_packer

Program loader that is the encode-side counterpart of the control decoder: accepts mnemonic-level operation descriptors over a valid/ready stream, encodes each into a 9-bit machine word (4-bit opcode, 5-bit operand), and writes the words sequentially into instruction memory. It sits between the testbench or boot source and the instruction-memory write port, and is active only before the core is released from reset.

## Interface
Parameters:
- IW, 9: machine word width ({opcode[3:0], operand[4:0]}).
- AW, 8: instruction-memory address width. Capacity is 2**AW words.

Ports:
- Clk, input, 1: single clock. All state updates on the rising edge.
- Reset, input, 1: synchronous, active-high.
- start, input, 1: begin a new program load. Clears the address counter.
- finish, input, 1: end the current load.
- in_valid, input, 1: descriptor present.
- in_ready, output, 1: packer can accept a descriptor.
- in_op, input, 5: mnemonic, type op_kind_e.
- in_operand, input, 5: raw operand (immediate, address, LUT index, or register field).
- mem_we, output, 1: instruction-memory write strobe.
- mem_addr, output, AW: write address.
- mem_wdata, output, IW: encoded word.
- count, output, AW+1: number of words written in the current load.
- busy, output, 1: state is LOAD.
- done, output, 1: state is DONE.
- err, output, 1: state is ERR.
- checksum, output, IW: exists only under PACKER_CHECKSUM_EN.

## Operation
- States: IDLE, LOAD, DONE, ERR. Reset value is IDLE.
- IDLE, DONE, or ERR with start: go to LOAD, set count to 0, clear checksum.
- LOAD with finish: go to DONE.
- LOAD with an illegal beat accepted: go to ERR.
- in_ready = (state==LOAD) && (count < 2**AW).
- Handshake: a beat is accepted when in_valid && in_ready. in_op and in_operand must stay stable while in_valid=1 && in_ready=0.
- Opcode map:
  - LI=0000, LD=0001, ST=0010, MOV=0011
  - ADD/SUB=0100, SHIFT=0101, XOR=0110, AND/OR=0111
  - BANK=1000, JMP=1001, BEQ=1010, ANDI=1011
  - EXCESS=1100, LDR=1101, STR=1110, RDX=1111
- Selector ops (ADD, SUB, AND, OR):
  - operand field = {in_operand[3:0], sel}, with sel=1 for ADD/AND and sel=0 for SUB/OR.
  - in_operand[4]=1 is illegal.
- All other ops: operand field = in_operand.
- in_op values outside op_kind_e are illegal.
- An illegal beat is consumed but not written. count does not change.
- When count reaches 2**AW, in_ready drops. Further beats stall; the counter never wraps.

## Timing
- All outputs are registered. Reset values: mem_we=0, mem_addr=0, mem_wdata=0, count=0, busy=0, done=0, err=0, checksum=0. in_ready is 0 during reset and in IDLE.
- Latency: a legal beat accepted in cycle N produces mem_we=1 in cycle N+1, with mem_addr = count before increment. count increments in cycle N+1.
- Throughput is 1 word per cycle. mem_we is a single-cycle pulse per word.
- busy, done, and err reflect the state register with no extra delay.
- finish together with an accepted beat: the beat is written, then the state becomes DONE.
- start in IDLE with in_valid=1: start wins. No beat is accepted that cycle because in_ready=0.
- start while in LOAD is ignored.
- Reset mid-load: the next cycle is IDLE with all outputs at reset values. Already-written memory contents are not undone.

## Configuration
- PACKER_CHECKSUM_EN defined:
  - checksum port exists.
  - On every write cycle, checksum ^= mem_wdata.
  - Cleared on start and on Reset.
  - Holds its value in DONE and ERR.
- PACKER_CHECKSUM_EN undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package packer_pkg holds:
  - op_kind_e, the 18 mnemonics.
  - Named 4-bit opcode constants, which are the same values the decoder consumes.
  - state_e.
- One sub-module, op_encoder: purely combinational. Inputs are in_op and in_operand; outputs are the IW-bit word and a legal flag.
- instr_packer owns the FSM, the counter, the output registers and the checksum.

## Test plan
- Load LI 5, ADD 3, SUB 3, finish → writes 0x005@0, 0x087@1, 0x086@2. Then done=1, count=3.
- AND with in_operand=16 → no write, err=1, count unchanged. A following start → busy=1, count=0.
- AW=2, stream 6 beats with in_valid held → 4 writes at addresses 0..3. in_ready=0 afterwards, count=4, no wrap.
- finish in the same cycle as BEQ 9 → 0x149 is written, then done=1. A subsequent in_valid is not accepted.
- Reset asserted after 2 writes → next cycle is IDLE, mem_we=0, count=0, in_ready=0.
- PACKER_CHECKSUM_EN with words 0x005, 0x087 → checksum=0x082. Without the macro, the design elaborates with no checksum port.
